// File: rtl/gf8_pkg.sv
// Shared constants and FSM encoding for the GF(8) LLR message path.
package gf8_pkg;

    localparam int GF_Q     = 8;
    localparam int GF_M     = 3;
    localparam int LLR_IN_W = 8;
    localparam int LLR_W    = 6;
    localparam logic [LLR_W-1:0] LLR_MAX = LLR_W'(63);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FIN     = 2'd3
    } nw_state_t;

endpackage

// File: rtl/llr_norm_writer_if.sv
// Input LLR stream plus message-RAM write port of the normalising writer.
interface llr_norm_writer_if;
    import gf8_pkg::*;

    logic                In_valid;
    logic                In_ready;
    logic [LLR_IN_W-1:0] In_llr;
    logic                We;
    logic [GF_M-1:0]     Waddr;
    logic [LLR_W-1:0]    Din;
    logic                Done;
    logic                Busy;

    modport master (
        output In_valid, In_llr,
        input  In_ready, We, Waddr, Din, Done, Busy
    );

    modport slave (
        input  In_valid, In_llr,
        output In_ready, We, Waddr, Din, Done, Busy
    );

endinterface

// File: rtl/sat_sub.sv
// Unsigned a-b clamped to MAX and narrowed to OUT_W bits; caller guarantees a >= b.
module sat_sub #(
    parameter int               IN_W  = 8,
    parameter int               OUT_W = 6,
    parameter logic [OUT_W-1:0] MAX   = '1
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] y
);

    logic [IN_W-1:0] diff;

    assign diff = a - b;
    assign y    = (diff > IN_W'(MAX)) ? MAX : diff[OUT_W-1:0];

endmodule

// File: rtl/llr_norm_writer.sv
// Buffers one 8-symbol LLR message, subtracts its minimum, saturates to 6 bits
// and streams the result into the message RAM write port.
//
//  state   | meaning
//  IDLE    | first cycle after reset
//  COLLECT | accepting samples, tracking running minimum
//  WRITE   | 8 RAM writes, address 0..7
//  FIN     | Done pulse, then back to COLLECT
module llr_norm_writer
    import gf8_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    llr_norm_writer_if.slave bus
);

    nw_state_t state, state_nxt;

    logic [LLR_IN_W-1:0] llr_buf [GF_Q];
    logic [LLR_IN_W-1:0] min_q, min_nxt;
    logic [GF_M-1:0]     rcnt, wcnt;
    logic                hs;

    logic [GF_M-1:0]     rd_idx;
    logic [LLR_IN_W-1:0] rd_min;
    logic [LLR_W-1:0]    sat_y;

    logic                in_ready_q, we_q, done_q, busy_q;
    logic [GF_M-1:0]     waddr_q;
    logic [LLR_W-1:0]    din_q;
    logic                in_ready_nxt, we_nxt, done_nxt, busy_nxt;
    logic [GF_M-1:0]     waddr_nxt;

    assign hs      = bus.In_valid && in_ready_q && (state == ST_COLLECT);
    assign min_nxt = (rcnt == '0) ? bus.In_llr
                   : ((bus.In_llr < min_q) ? bus.In_llr : min_q);

    // On the last handshake edge the fresh minimum is still combinational,
    // so word 0 is normalised against min_nxt rather than min_q.
    sat_sub #(
        .IN_W  (LLR_IN_W),
        .OUT_W (LLR_W),
        .MAX   (LLR_MAX)
    ) u_sat (
        .a (llr_buf[rd_idx]),
        .b (rd_min),
        .y (sat_y)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        in_ready_nxt = 1'b0;
        we_nxt       = 1'b0;
        waddr_nxt    = '0;
        done_nxt     = 1'b0;
        busy_nxt     = busy_q;
        rd_idx       = wcnt + 1'b1;
        rd_min       = min_q;
        case (state)
            ST_IDLE: begin
                state_nxt    = ST_COLLECT;
                in_ready_nxt = 1'b1;
            end
            ST_COLLECT: begin
                in_ready_nxt = 1'b1;
                rd_idx       = '0;
                rd_min       = min_nxt;
                if (hs) begin
                    busy_nxt = 1'b1;
                    if (rcnt == GF_M'(GF_Q - 1)) begin
                        state_nxt    = ST_WRITE;
                        in_ready_nxt = 1'b0;
                        we_nxt       = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (wcnt == GF_M'(GF_Q - 1)) begin
                    state_nxt = ST_FIN;
                    done_nxt  = 1'b1;
                end else begin
                    we_nxt    = 1'b1;
                    waddr_nxt = wcnt + 1'b1;
                end
            end
            ST_FIN: begin
                state_nxt    = ST_COLLECT;
                in_ready_nxt = 1'b1;
                busy_nxt     = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rcnt  <= '0;
            wcnt  <= '0;
            min_q <= '1;
            for (int i = 0; i < GF_Q; i++) llr_buf[i] <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    wcnt <= '0;
                    if (hs) begin
                        llr_buf[rcnt] <= bus.In_llr;
                        rcnt          <= rcnt + 1'b1;
                        min_q         <= min_nxt;
                    end
                end
                ST_WRITE: wcnt <= wcnt + 1'b1;
                ST_FIN: begin
                    rcnt  <= '0;
                    wcnt  <= '0;
                    min_q <= '1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            in_ready_q <= in_ready_nxt;
            we_q       <= we_nxt;
            waddr_q    <= waddr_nxt;
            din_q      <= we_nxt ? sat_y : '0;
            done_q     <= done_nxt;
            busy_q     <= busy_nxt;
        end
    end

    assign bus.In_ready = in_ready_q;
    assign bus.We       = we_q;
    assign bus.Waddr    = waddr_q;
    assign bus.Din      = din_q;
    assign bus.Done     = done_q;
    assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_llr_norm_writer.sv
// Directed + randomised bench for llr_norm_writer against a min/subtract/clamp model.
module tb_llr_norm_writer;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc_cnt = 0;
    int   first_hs_cyc = 0;

    llr_norm_writer_if bus ();

    llr_norm_writer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Asserted between clock edges: outputs must drop with no edge in between.
    task automatic hit_reset_now();
        Rst = 1'b1;
        bus.In_valid = 1'b0;
        #1;
        chk("rst_ready", bus.In_ready, 0);
        chk("rst_we",    bus.We,       0);
        chk("rst_waddr", bus.Waddr,    0);
        chk("rst_din",   bus.Din,      0);
        chk("rst_done",  bus.Done,     0);
        chk("rst_busy",  bus.Busy,     0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("idle_ready", bus.In_ready, 0);
    endtask

    task automatic run_msg(input logic [7:0] v [8], input bit gaps, input bit junk,
                           input int abort_hs, input int abort_we);
        int exp_din [8];
        int mn;
        int acc;
        int cyc;
        mn = 255;
        for (int i = 0; i < 8; i++) if (int'(v[i]) < mn) mn = int'(v[i]);
        for (int i = 0; i < 8; i++) begin
            exp_din[i] = int'(v[i]) - mn;
            if (exp_din[i] > 63) exp_din[i] = 63;
        end
        acc = 0;
        cyc = 0;
        while (acc < 8) begin
            @(negedge Clk);
            cyc++;
            if (cyc > 300) begin
                chk("collect_timeout", acc, 8);
                bus.In_valid = 1'b0;
                return;
            end
            chk("collect_we",   bus.We,   0);
            chk("collect_done", bus.Done, 0);
            chk("collect_busy", bus.Busy, (acc > 0));
            bus.In_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.In_llr   = bus.In_valid ? v[acc] : 8'($urandom);
            if (bus.In_valid && bus.In_ready) begin
                if (acc == 0) first_hs_cyc = cyc_cnt;
                acc++;
                if (acc == abort_hs) begin
                    @(posedge Clk);
                    #2;
                    hit_reset_now();
                    return;
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            bus.In_valid = junk;
            bus.In_llr   = 8'($urandom);
            chk("wr_we",    bus.We,       1);
            chk("wr_waddr", bus.Waddr,    k);
            chk("wr_din",   bus.Din,      exp_din[k]);
            chk("wr_ready", bus.In_ready, 0);
            chk("wr_done",  bus.Done,     0);
            chk("wr_busy",  bus.Busy,     1);
            if (k + 1 == abort_we) begin
                #1;
                hit_reset_now();
                return;
            end
        end
        @(negedge Clk);
        bus.In_valid = junk;
        bus.In_llr   = 8'($urandom);
        chk("fin_done",  bus.Done,     1);
        chk("fin_we",    bus.We,       0);
        chk("fin_ready", bus.In_ready, 0);
        chk("fin_busy",  bus.Busy,     1);
    endtask

    initial begin
        logic [7:0] msg [8];
        int t1;
        bus.In_valid = 1'b0;
        bus.In_llr   = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("reset_ready", bus.In_ready, 0);
        chk("reset_we",    bus.We,       0);
        chk("reset_waddr", bus.Waddr,    0);
        chk("reset_din",   bus.Din,      0);
        chk("reset_done",  bus.Done,     0);
        chk("reset_busy",  bus.Busy,     0);
        Rst = 1'b0;
        #1;
        chk("idle_ready", bus.In_ready, 0);

        msg = '{8'd10, 8'd20, 8'd5, 8'd5, 8'd70, 8'd100, 8'd255, 8'd6};
        run_msg(msg, 1'b0, 1'b0, -1, -1);

        msg = '{8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42, 8'd42};
        run_msg(msg, 1'b0, 1'b0, -1, -1);

        msg = '{8'd0, 8'd1, 8'd63, 8'd64, 8'd200, 8'd255, 8'd2, 8'd3};
        run_msg(msg, 1'b0, 1'b0, -1, -1);

        msg = '{8'd90, 8'd33, 8'd140, 8'd31, 8'd77, 8'd95, 8'd32, 8'd250};
        run_msg(msg, 1'b1, 1'b1, -1, -1);

        msg = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        run_msg(msg, 1'b0, 1'b1, -1, -1);
        t1 = first_hs_cyc;
        msg = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
        run_msg(msg, 1'b0, 1'b1, -1, -1);
        chk("b2b_period", first_hs_cyc - t1, 17);

        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 8; i++)
                msg[i] = (m[0]) ? 8'($urandom_range(100, 180)) : 8'($urandom);
            run_msg(msg, 1'b1, 1'b1, -1, -1);
        end

        msg = '{8'd0, 8'd9, 8'd18, 8'd27, 8'd36, 8'd45, 8'd54, 8'd63};
        run_msg(msg, 1'b0, 1'b0, -1, 3);
        msg = '{8'd80, 8'd50, 8'd120, 8'd51, 8'd99, 8'd70, 8'd113, 8'd60};
        run_msg(msg, 1'b0, 1'b0, -1, -1);

        msg = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        run_msg(msg, 1'b1, 1'b0, 5, -1);
        msg = '{8'd150, 8'd170, 8'd160, 8'd230, 8'd155, 8'd199, 8'd210, 8'd152};
        run_msg(msg, 1'b0, 1'b0, -1, -1);

        bus.In_valid = 1'b0;
        @(negedge Clk);
        chk("end_ready", bus.In_ready, 1);
        chk("end_done",  bus.Done,     0);
        chk("end_busy",  bus.Busy,     0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
